// File: rtl/dn_mem_writer.sv
// -----------------------------------------------------------------------------
// dn_mem_writer
//
// Receiving end of the boot-loader download stream. Each {dn_addr, dn_data}
// strobe is buffered in a small FIFO and written to system memory, one byte
// at a time, through a level-held req / single-cycle ack port into the
// memory arbiter. The CPU is held while a load is in progress and is released
// (optionally with a start pulse and captured PC) once every buffered byte has
// been committed.
//
// Ports
//   clk_sys, reset_n      system clock, asynchronous active-low reset
//   dn_go                 download window, high while the loader streams
//   dn_wr/dn_addr/dn_data single-cycle byte write strobe with address/data
//   dn_wait               registered back-pressure towards the loader
//   exec_req/exec_addr    request to start execution at exec_addr
//   mem_req/mem_addr/
//   mem_din/mem_ack       memory write port (req held until ack)
//   cpu_hold              holds the CPU during a load
//   exec_pulse/exec_pc    one-cycle start strobe and captured start address
//   byte_count            bytes committed to memory in the current load
//   overflow              sticky: a strobe arrived while the FIFO was full
// -----------------------------------------------------------------------------
module dn_mem_writer #(
   parameter int unsigned MEM_AW     = 21,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              dn_go,
   input  logic              dn_wr,
   input  logic [15:0]       dn_addr,
   input  logic [7:0]        dn_data,
   output logic              dn_wait,
   input  logic              exec_req,
   input  logic [15:0]       exec_addr,
   output logic              mem_req,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_din,
   input  logic              mem_ack,
   output logic              cpu_hold,
   output logic              exec_pulse,
   output logic [15:0]       exec_pc,
   output logic [16:0]       byte_count,
   output logic              overflow
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FW = PW + 1;

   localparam logic [MEM_AW-1:0] BASE      = MEM_AW'(BASE_ADDR);
   localparam logic [FW-1:0]     FILL_FULL = FW'(FIFO_DEPTH);
   localparam logic [FW-1:0]     FILL_WAIT = FW'(FIFO_DEPTH - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } mem_state_t;

   // FIFO storage and bookkeeping
   logic [15:0]   fifo_addr [FIFO_DEPTH];
   logic [7:0]    fifo_data [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [FW-1:0] fill;
   logic [FW-1:0] fill_next;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;

   // Memory FSM
   mem_state_t    state;
   mem_state_t    state_next;
   logic          load;

   // Load / exec control
   logic          dn_go_q;
   logic          go_rise;
   logic          exec_pending;
   logic          release_now;
   logic          fire;

   assign fifo_empty = (fill == '0);
   assign fifo_full  = (fill == FILL_FULL);

   // Strobes outside the download window are ignored; strobes into a full
   // FIFO are dropped and flagged through overflow.
   assign push = dn_go && dn_wr && !fifo_full;

   // ---------------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------------
   // NOTE: the storage array carries no reset; pointers and fill alone decide
   // which entries are valid, so clearing the contents would buy nothing.
   always_ff @(posedge clk_sys) begin
      if (push) begin
         fifo_addr[wr_ptr] <= dn_addr;
         fifo_data[wr_ptr] <= dn_data;
      end
   end

   always_comb begin
      fill_next = fill;
      case ({push, pop})
         2'b10:   fill_next = fill + FW'(1);
         2'b01:   fill_next = fill - FW'(1);
         default: fill_next = fill;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         fill    <= '0;
         dn_wait <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         fill    <= fill_next;
         // Raised one entry early so a strobe already in flight still fits.
         dn_wait <= (fill_next >= FILL_WAIT);
      end
   end

   // ---------------------------------------------------------------------------
   // Memory write FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (!fifo_empty) state_next = S_REQ;
         S_REQ:   if (mem_ack)     state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // The head entry is popped only on ack, so mem_addr/mem_din captured at
   // load time stay stable for the whole request. An ack while idle is ignored.
   always_comb begin
      load    = (state == S_IDLE) && !fifo_empty;
      pop     = (state == S_REQ) && mem_ack;
      mem_req = (state == S_REQ);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mem_addr <= '0;
         mem_din  <= '0;
      end else if (load) begin
         // Address arithmetic wraps modulo 2^MEM_AW by truncation.
         mem_addr <= BASE + MEM_AW'(fifo_addr[rd_ptr]);
         mem_din  <= fifo_data[rd_ptr];
      end
   end

   // ---------------------------------------------------------------------------
   // Load window, exec hand-over and status
   // ---------------------------------------------------------------------------
   assign go_rise     = dn_go && !dn_go_q;
   // Bytes queued from an earlier window keep draining; release waits for them.
   assign release_now = cpu_hold && !dn_go && fifo_empty &&
                        (state == S_IDLE) && !mem_req;
   // An exec_req arriving in the release cycle itself still earns its pulse.
   assign fire        = release_now && (exec_pending || exec_req);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dn_go_q      <= 1'b0;
         cpu_hold     <= 1'b0;
         exec_pending <= 1'b0;
         exec_pulse   <= 1'b0;
         exec_pc      <= '0;
         byte_count   <= '0;
         overflow     <= 1'b0;
      end else begin
         dn_go_q    <= dn_go;
         exec_pulse <= fire;

         if (go_rise)          cpu_hold <= 1'b1;
         else if (release_now) cpu_hold <= 1'b0;

         if (exec_req) exec_pc <= exec_addr;

         // A fresh exec_req outranks the clear on dn_go rise: it is the
         // newer event.
         if (fire)          exec_pending <= 1'b0;
         else if (exec_req) exec_pending <= 1'b1;
         else if (go_rise)  exec_pending <= 1'b0;

         if (go_rise)                   byte_count <= '0;
         else if (pop && ~&byte_count) byte_count <= byte_count + 17'd1;

         // A drop in the rise cycle belongs to the new load, so set wins.
         if (dn_go && dn_wr && fifo_full) overflow <= 1'b1;
         else if (go_rise)                overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dn_mem_writer.sv
// -----------------------------------------------------------------------------
// tb_dn_mem_writer
//
// Directed bench for dn_mem_writer. Every accepted byte is pushed to a
// scoreboard queue when strobed; a memory responder pops and compares it when
// the DUT presents the request. A second instance with a high BASE_ADDR
// covers address wrap.
// -----------------------------------------------------------------------------
module tb_dn_mem_writer;

   localparam int unsigned MEM_AW = 21;

   typedef struct packed {
      logic [MEM_AW-1:0] addr;
      logic [7:0]        data;
   } sb_entry_t;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic              reset_n;
   logic              dn_go;
   logic              dn_wr;
   logic [15:0]       dn_addr;
   logic [7:0]        dn_data;
   logic              exec_req;
   logic [15:0]       exec_addr;
   logic              ack_r;
   logic              stray_ack;
   logic              mem_ack;
   logic              dn_wait;
   logic              mem_req;
   logic [MEM_AW-1:0] mem_addr;
   logic [7:0]        mem_din;
   logic              cpu_hold;
   logic              exec_pulse;
   logic [15:0]       exec_pc;
   logic [16:0]       byte_count;
   logic              overflow;

   // Wrap-test instance signals
   logic              dn_wr_w;
   logic              mem_ack_w;
   logic              dn_wait_w;
   logic              mem_req_w;
   logic [MEM_AW-1:0] mem_addr_w;
   logic [7:0]        mem_din_w;
   logic              cpu_hold_w;
   logic              exec_pulse_w;
   logic [15:0]       exec_pc_w;
   logic [16:0]       byte_count_w;
   logic              overflow_w;

   assign mem_ack = ack_r | stray_ack;

   dn_mem_writer #(.MEM_AW(MEM_AW), .BASE_ADDR(0), .FIFO_DEPTH(4)) u_dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .dn_go      (dn_go),
      .dn_wr      (dn_wr),
      .dn_addr    (dn_addr),
      .dn_data    (dn_data),
      .dn_wait    (dn_wait),
      .exec_req   (exec_req),
      .exec_addr  (exec_addr),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_ack    (mem_ack),
      .cpu_hold   (cpu_hold),
      .exec_pulse (exec_pulse),
      .exec_pc    (exec_pc),
      .byte_count (byte_count),
      .overflow   (overflow)
   );

   dn_mem_writer #(.MEM_AW(MEM_AW), .BASE_ADDR(32'h001F_FFF0), .FIFO_DEPTH(4)) u_wrap (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .dn_go      (dn_go),
      .dn_wr      (dn_wr_w),
      .dn_addr    (dn_addr),
      .dn_data    (dn_data),
      .dn_wait    (dn_wait_w),
      .exec_req   (exec_req),
      .exec_addr  (exec_addr),
      .mem_req    (mem_req_w),
      .mem_addr   (mem_addr_w),
      .mem_din    (mem_din_w),
      .mem_ack    (mem_ack_w),
      .cpu_hold   (cpu_hold_w),
      .exec_pulse (exec_pulse_w),
      .exec_pc    (exec_pc_w),
      .byte_count (byte_count_w),
      .overflow   (overflow_w)
   );

   int        n_checks = 0;
   int        n_errors = 0;
   sb_entry_t sb[$];
   bit        ack_en;
   int        ack_delay;
   int        req_age;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic sb_entry_t mk(input logic [15:0] a, input logic [7:0] d);
      sb_entry_t e;
      e.addr = MEM_AW'(a);
      e.data = d;
      return e;
   endfunction

   // Memory responder: acks ack_delay cycles after it first sees mem_req and
   // compares the presented byte against the scoreboard head.
   always @(negedge clk_sys) begin
      if (ack_r) begin
         ack_r = 1'b0;
      end else if (ack_en && mem_req === 1'b1) begin
         if (req_age >= ack_delay) begin
            check("mem_req_has_expected_byte", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               sb_entry_t e;
               e = sb.pop_front();
               check("mem_addr", 32'(mem_addr), 32'(e.addr));
               check("mem_din", 32'(mem_din), 32'(e.data));
            end
            ack_r   = 1'b1;
            req_age = 0;
         end else begin
            req_age++;
         end
      end else begin
         req_age = 0;
      end
   end

   initial begin
      int          pulses;
      logic        hold_at;
      logic [16:0] count_at;
      logic        saw_wait;
      logic        w2;
      logic        w3;
      logic        req_seen;
      logic        hold_seen;
      bit          found;

      // ---------------- reset state ----------------
      reset_n   = 1'b0;
      dn_go     = 1'b0;
      dn_wr     = 1'b0;
      dn_addr   = '0;
      dn_data   = '0;
      exec_req  = 1'b0;
      exec_addr = '0;
      ack_r     = 1'b0;
      stray_ack = 1'b0;
      ack_en    = 1'b0;
      ack_delay = 1;
      req_age   = 0;
      dn_wr_w   = 1'b0;
      mem_ack_w = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
      check("rst_dn_wait", 32'(dn_wait), 32'd0);
      check("rst_byte_count", 32'(byte_count), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_exec_pulse", 32'(exec_pulse), 32'd0);
      reset_n = 1'b1;
      @(negedge clk_sys);

      // ---------------- single byte ----------------
      ack_en    = 1'b1;
      ack_delay = 1;
      dn_go     = 1'b1;
      @(negedge clk_sys);
      check("t1_cpu_hold_on_go", 32'(cpu_hold), 32'd1);
      dn_wr   = 1'b1;
      dn_addr = 16'h0000;
      dn_data = 8'hC3;
      sb.push_back(mk(16'h0000, 8'hC3));
      @(negedge clk_sys);
      dn_wr = 1'b0;
      check("t1_no_req_in_push_cycle", 32'(mem_req), 32'd0);
      @(negedge clk_sys);
      check("t1_req_after_push", 32'(mem_req), 32'd1);
      check("t1_mem_addr", 32'(mem_addr), 32'd0);
      check("t1_mem_din", 32'(mem_din), 32'hC3);
      exec_req  = 1'b1;
      exec_addr = 16'h0000;
      dn_go     = 1'b0;
      pulses    = 0;
      hold_at   = 1'b1;
      count_at  = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_sys);
         exec_req = 1'b0;
         if (exec_pulse === 1'b1) begin
            pulses++;
            hold_at  = cpu_hold;
            count_at = byte_count;
         end
      end
      check("t1_exec_pulse_count", 32'(pulses), 32'd1);
      check("t1_hold_falls_with_pulse", 32'(hold_at), 32'd0);
      check("t1_byte_count", 32'(count_at), 32'd1);
      check("t1_exec_pc", 32'(exec_pc), 32'h0000);
      check("t1_sb_drained", 32'(sb.size()), 32'd0);

      // ---------------- back-pressure, 276 bytes ----------------
      ack_delay = 3;
      saw_wait  = 1'b0;
      dn_go     = 1'b1;
      @(negedge clk_sys);
      for (int i = 0; i < 276; i++) begin
         int guard;
         guard = 0;
         while (dn_wait === 1'b1 && guard < 200) begin
            saw_wait = 1'b1;
            @(negedge clk_sys);
            guard++;
         end
         if (guard >= 200) begin
            check("t2_dn_wait_timeout", 32'(dn_wait), 32'd0);
            break;
         end
         dn_wr   = 1'b1;
         dn_addr = 16'(i);
         dn_data = 8'(i * 7 + 3);
         sb.push_back(mk(16'(i), 8'(i * 7 + 3)));
         @(negedge clk_sys);
         dn_wr = 1'b0;
         if (dn_wait === 1'b1) saw_wait = 1'b1;
         @(negedge clk_sys);
      end
      dn_go     = 1'b0;
      exec_req  = 1'b1;
      exec_addr = 16'h1234;
      @(negedge clk_sys);
      exec_req = 1'b0;
      pulses   = 0;
      for (int i = 0; i < 4000 && pulses == 0; i++) begin
         @(negedge clk_sys);
         if (exec_pulse === 1'b1) pulses++;
      end
      check("t2_exec_pulse_seen", 32'(pulses), 32'd1);
      check("t2_byte_count", 32'(byte_count), 32'd276);
      check("t2_overflow", 32'(overflow), 32'd0);
      check("t2_exec_pc", 32'(exec_pc), 32'h1234);
      check("t2_dn_wait_raised", 32'(saw_wait), 32'd1);
      check("t2_sb_drained", 32'(sb.size()), 32'd0);
      @(negedge clk_sys);
      check("t2_cpu_hold_released", 32'(cpu_hold), 32'd0);

      // ---------------- overflow ----------------
      ack_en = 1'b0;
      dn_go  = 1'b1;
      @(negedge clk_sys);
      check("t3_byte_count_cleared", 32'(byte_count), 32'd0);
      w2 = 1'b1;
      w3 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) w2 = dn_wait;
         if (i == 3) w3 = dn_wait;
         dn_wr   = 1'b1;
         dn_addr = 16'h0100 + 16'(i);
         dn_data = 8'hA0 + 8'(i);
         if (i < 4) sb.push_back(mk(16'h0100 + 16'(i), 8'hA0 + 8'(i)));
         @(negedge clk_sys);
      end
      dn_wr = 1'b0;
      check("t3_dn_wait_fill2", 32'(w2), 32'd0);
      check("t3_dn_wait_fill3", 32'(w3), 32'd1);
      check("t3_overflow_set", 32'(overflow), 32'd1);
      check("t3_req_held", 32'(mem_req), 32'd1);
      check("t3_head_held", 32'(mem_din), 32'hA0);
      ack_en    = 1'b1;
      ack_delay = 1;
      found     = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk_sys);
         if (sb.size() == 0 && mem_req === 1'b0) found = 1'b1;
      end
      check("t3_drain_done", 32'(found), 32'd1);
      req_seen = 1'b0;
      repeat (10) begin
         @(negedge clk_sys);
         if (mem_req !== 1'b0) req_seen = 1'b1;
      end
      check("t3_no_dropped_bytes", 32'(req_seen), 32'd0);
      check("t3_byte_count", 32'(byte_count), 32'd4);
      check("t3_overflow_sticky", 32'(overflow), 32'd1);
      dn_go  = 1'b0;
      pulses = 0;
      repeat (10) begin
         @(negedge clk_sys);
         if (exec_pulse === 1'b1) pulses++;
      end
      check("t3_no_pulse_without_exec", 32'(pulses), 32'd0);
      check("t3_cpu_hold_released", 32'(cpu_hold), 32'd0);

      // ---------------- stray inputs ----------------
      dn_wr   = 1'b1;
      dn_addr = 16'h0055;
      dn_data = 8'h66;
      @(negedge clk_sys);
      @(negedge clk_sys);
      dn_wr    = 1'b0;
      req_seen = 1'b0;
      repeat (8) begin
         @(negedge clk_sys);
         if (mem_req !== 1'b0) req_seen = 1'b1;
      end
      check("t4_wr_without_go_ignored", 32'(req_seen), 32'd0);
      stray_ack = 1'b1;
      @(negedge clk_sys);
      stray_ack = 1'b0;
      req_seen  = 1'b0;
      repeat (5) begin
         @(negedge clk_sys);
         if (mem_req !== 1'b0) req_seen = 1'b1;
      end
      check("t4_idle_ack_no_req", 32'(req_seen), 32'd0);
      check("t4_idle_ack_count", 32'(byte_count), 32'd4);

      // ---------------- address wrap ----------------
      dn_go = 1'b1;
      @(negedge clk_sys);
      dn_wr_w = 1'b1;
      dn_addr = 16'h0020;
      dn_data = 8'h5A;
      @(negedge clk_sys);
      dn_wr_w = 1'b0;
      found   = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (mem_req_w === 1'b1) found = 1'b1;
         else @(negedge clk_sys);
      end
      check("t5_wrap_req", 32'(found), 32'd1);
      check("t5_wrap_addr", 32'(mem_addr_w), 32'h0000_0010);
      check("t5_wrap_data", 32'(mem_din_w), 32'h5A);
      mem_ack_w = 1'b1;
      @(negedge clk_sys);
      mem_ack_w = 1'b0;
      check("t5_wrap_count", 32'(byte_count_w), 32'd1);
      check("t5_wrap_req_dropped", 32'(mem_req_w), 32'd0);
      dn_go = 1'b0;
      repeat (3) @(negedge clk_sys);

      // ---------------- reset mid-write ----------------
      ack_en    = 1'b1;
      ack_delay = 1;
      dn_go     = 1'b1;
      @(negedge clk_sys);
      for (int i = 0; i < 2; i++) begin
         dn_wr   = 1'b1;
         dn_addr = 16'h0200 + 16'(i);
         dn_data = 8'h30 + 8'(i);
         sb.push_back(mk(16'h0200 + 16'(i), 8'h30 + 8'(i)));
         @(negedge clk_sys);
      end
      dn_wr = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (mem_req === 1'b1 && byte_count == 17'd1) begin
            found  = 1'b1;
            ack_en = 1'b0;
         end else begin
            @(negedge clk_sys);
         end
      end
      check("t6_second_req_pending", 32'(found), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("t6_async_mem_req", 32'(mem_req), 32'd0);
      check("t6_async_cpu_hold", 32'(cpu_hold), 32'd0);
      check("t6_async_byte_count", 32'(byte_count), 32'd0);
      sb.delete();
      dn_go = 1'b0;
      @(negedge clk_sys);
      reset_n   = 1'b1;
      ack_en    = 1'b1;
      req_seen  = 1'b0;
      hold_seen = 1'b0;
      repeat (10) begin
         @(negedge clk_sys);
         if (mem_req !== 1'b0) req_seen = 1'b1;
         if (cpu_hold !== 1'b0) hold_seen = 1'b1;
      end
      check("t6_no_req_after_reset", 32'(req_seen), 32'd0);
      check("t6_no_hold_after_reset", 32'(hold_seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
